// File: rtl/id_stage_pipe_if.sv
// Decode-stage bus: decoded instruction and writeback port in,
// ID/EX pipeline register contents and handshake out.
interface id_stage_pipe_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    dest;
    logic [AW-1:0]    sr1;
    logic [AW-1:0]    sr2;
    logic             uses_sr1;
    logic             uses_sr2;
    logic             writes_dest;
    logic             is_load;
    logic             store_sel;
    logic             jsr_sel;
    logic             wb_load;
    logic [AW-1:0]    wb_dest;
    logic [WIDTH-1:0] wb_data;
    logic             flush;
    logic             ex_stall;
    logic             out_valid;
    logic [AW-1:0]    out_dest;
    logic [WIDTH-1:0] out_srca_data;
    logic [WIDTH-1:0] out_sr2_data;
    logic             out_writes_dest;
    logic             out_is_load;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output in_valid, dest, sr1, sr2, uses_sr1, uses_sr2, writes_dest,
               is_load, store_sel, jsr_sel, wb_load, wb_dest, wb_data,
               flush, ex_stall,
        input  in_ready, out_valid, out_dest, out_srca_data, out_sr2_data,
               out_writes_dest, out_is_load, bubble_cnt
    );

    modport slave (
        input  in_valid, dest, sr1, sr2, uses_sr1, uses_sr2, writes_dest,
               is_load, store_sel, jsr_sel, wb_load, wb_dest, wb_data,
               flush, ex_stall,
        output in_ready, out_valid, out_dest, out_srca_data, out_sr2_data,
               out_writes_dest, out_is_load, bubble_cnt
    );
endinterface

// File: rtl/id_stage_pipe.sv
// LC-3b decode stage: register file with writeback bypass, load-use hazard
// detection and the ID/EX pipeline register with a saturating bubble counter.
module id_stage_pipe #(
    parameter int WIDTH    = 16,
    parameter int NREGS    = 8,
    parameter int AW       = $clog2(NREGS),
    parameter int LINK_REG = NREGS - 1,
    parameter bit R0_ZERO  = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic           clk,
    input  logic           reset,
    id_stage_pipe_if.slave bus
);
    localparam logic [AW-1:0] LP_LINK = AW'(LINK_REG);
    localparam logic [AW-1:0] LP_R0   = '0;

    logic [WIDTH-1:0] r_rf [NREGS];
    logic             r_out_valid;
    logic [AW-1:0]    r_out_dest;
    logic [WIDTH-1:0] r_out_srca_data;
    logic [WIDTH-1:0] r_out_sr2_data;
    logic             r_out_writes_dest;
    logic             r_out_is_load;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic [AW-1:0]    w_srca_addr;
    logic [AW-1:0]    w_dest_eff;
    logic [WIDTH-1:0] w_srca_data;
    logic [WIDTH-1:0] w_sr2_data;
    logic             w_wr_en;
    logic             w_hit;
    logic             w_hz;

    assign w_srca_addr = bus.store_sel ? bus.dest : bus.sr1;
    assign w_dest_eff  = bus.jsr_sel ? LP_LINK : bus.dest;
    assign w_wr_en     = bus.wb_load && !(R0_ZERO && bus.wb_dest == LP_R0);

    // Hard-wired zero overrides the bypass, so it is applied last.
    always_comb begin
        w_srca_data = r_rf[w_srca_addr];
        if (bus.wb_load && bus.wb_dest == w_srca_addr) w_srca_data = bus.wb_data;
        if (R0_ZERO && w_srca_addr == LP_R0) w_srca_data = '0;
    end

    always_comb begin
        w_sr2_data = r_rf[bus.sr2];
        if (bus.wb_load && bus.wb_dest == bus.sr2) w_sr2_data = bus.wb_data;
        if (R0_ZERO && bus.sr2 == LP_R0) w_sr2_data = '0;
    end

    assign w_hit = (bus.uses_sr1 && w_srca_addr == r_out_dest) ||
                   (bus.uses_sr2 && bus.sr2 == r_out_dest);
    assign w_hz  = bus.in_valid && r_out_valid && r_out_is_load && r_out_writes_dest &&
                   w_hit && !(R0_ZERO && r_out_dest == LP_R0);

    assign bus.in_ready = !reset && (bus.flush || (!bus.ex_stall && !w_hz));

    // NOTE: the register file is architecturally cleared by reset, so every
    // entry is reset here; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else if (w_wr_en) begin
            r_rf[bus.wb_dest] <= bus.wb_data;
        end
    end

    // Flush outranks stall, stall outranks the bubble, so a held or squashed
    // cycle never counts as a hazard.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid       <= 1'b0;
            r_out_dest        <= '0;
            r_out_srca_data   <= '0;
            r_out_sr2_data    <= '0;
            r_out_writes_dest <= 1'b0;
            r_out_is_load     <= 1'b0;
            r_bubble_cnt      <= '0;
        end else if (bus.flush) begin
            r_out_valid       <= 1'b0;
            r_out_writes_dest <= 1'b0;
            r_out_is_load     <= 1'b0;
        end else if (bus.ex_stall) begin
            r_out_valid       <= r_out_valid;
        end else if (w_hz) begin
            r_out_valid       <= 1'b0;
            r_out_writes_dest <= 1'b0;
            r_out_is_load     <= 1'b0;
            if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end else if (bus.in_valid) begin
            r_out_valid       <= 1'b1;
            r_out_dest        <= w_dest_eff;
            r_out_srca_data   <= w_srca_data;
            r_out_sr2_data    <= w_sr2_data;
            r_out_writes_dest <= bus.writes_dest;
            r_out_is_load     <= bus.is_load;
        end else begin
            r_out_valid       <= 1'b0;
            r_out_writes_dest <= 1'b0;
            r_out_is_load     <= 1'b0;
        end
    end

    assign bus.out_valid       = r_out_valid;
    assign bus.out_dest        = r_out_dest;
    assign bus.out_srca_data   = r_out_srca_data;
    assign bus.out_sr2_data    = r_out_sr2_data;
    assign bus.out_writes_dest = r_out_writes_dest;
    assign bus.out_is_load     = r_out_is_load;
    assign bus.bubble_cnt      = r_bubble_cnt;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: two configurations driven with identical stimulus
// and compared every cycle against a cycle-level reference model.
module tb_id_stage_pipe;
    typedef struct packed {
        logic        reset;
        logic        in_valid;
        logic [3:0]  dest;
        logic [3:0]  sr1;
        logic [3:0]  sr2;
        logic        uses_sr1;
        logic        uses_sr2;
        logic        writes_dest;
        logic        is_load;
        logic        store_sel;
        logic        jsr_sel;
        logic        wb_load;
        logic [3:0]  wb_dest;
        logic [31:0] wb_data;
        logic        flush;
        logic        ex_stall;
    } stim_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.WIDTH(16), .AW(3), .CNT_W(16)) bus0 ();
    id_stage_pipe_if #(.WIDTH(32), .AW(4), .CNT_W(2))  bus1 ();

    id_stage_pipe #(.WIDTH(16), .NREGS(8), .R0_ZERO(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    id_stage_pipe #(.WIDTH(32), .NREGS(16), .R0_ZERO(1'b1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model state per configuration.
    int          nregs_c [2] = '{8, 16};
    bit          r0z_c   [2] = '{1'b0, 1'b1};
    logic [31:0] wmask_c [2] = '{32'h0000_FFFF, 32'hFFFF_FFFF};
    int unsigned cmax_c  [2] = '{32'd65535, 32'd3};
    logic [31:0] m_rf  [2][16];
    logic        m_ov  [2];
    logic        m_wd  [2];
    logic        m_il  [2];
    logic        m_fk  [2];
    logic        m_dk  [2];
    logic [3:0]  m_od  [2];
    logic [31:0] m_a   [2];
    logic [31:0] m_b   [2];
    int unsigned m_cnt [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic logic [31:0] m_read(input int k, input logic [3:0] addr,
                                           input stim_t s, input logic [3:0] wa);
        if (r0z_c[k] && addr == 4'd0) return 32'd0;
        if (s.wb_load && wa == addr) return s.wb_data & wmask_c[k];
        return m_rf[k][addr];
    endfunction

    task automatic model_step(input int k, input stim_t s, output logic rdy);
        logic [3:0]  am, d, s1, s2, sa, de, wa;
        logic        hz;
        logic [31:0] va, vb;
        am = 4'(nregs_c[k] - 1);
        d  = s.dest & am;
        s1 = s.sr1 & am;
        s2 = s.sr2 & am;
        wa = s.wb_dest & am;
        sa = s.store_sel ? d : s1;
        de = s.jsr_sel ? am : d;
        hz = s.in_valid && m_ov[k] && m_il[k] && m_wd[k] &&
             ((s.uses_sr1 && sa == m_od[k]) || (s.uses_sr2 && s2 == m_od[k]));
        if (r0z_c[k] && m_od[k] == 4'd0) hz = 1'b0;
        rdy = !s.reset && (s.flush || (!s.ex_stall && !hz));
        va = m_read(k, sa, s, wa);
        vb = m_read(k, s2, s, wa);
        if (s.reset) begin
            for (int i = 0; i < 16; i++) m_rf[k][i] = 32'd0;
            m_ov[k] = 0; m_wd[k] = 0; m_il[k] = 0; m_od[k] = 0;
            m_a[k] = 0; m_b[k] = 0; m_cnt[k] = 0; m_fk[k] = 1; m_dk[k] = 1;
        end else begin
            if (s.wb_load && !(r0z_c[k] && wa == 4'd0)) m_rf[k][wa] = s.wb_data & wmask_c[k];
            if (s.flush) begin
                m_ov[k] = 0; m_wd[k] = 0; m_il[k] = 0; m_fk[k] = 1; m_dk[k] = 0;
            end else if (s.ex_stall) begin
                m_ov[k] = m_ov[k];
            end else if (hz) begin
                m_ov[k] = 0; m_wd[k] = 0; m_il[k] = 0; m_fk[k] = 1; m_dk[k] = 0;
                if (m_cnt[k] < cmax_c[k]) m_cnt[k]++;
            end else if (s.in_valid) begin
                m_ov[k] = 1; m_od[k] = de; m_a[k] = va; m_b[k] = vb;
                m_wd[k] = s.writes_dest; m_il[k] = s.is_load; m_fk[k] = 1; m_dk[k] = 1;
            end else begin
                m_ov[k] = 0; m_fk[k] = 0; m_dk[k] = 0;
            end
        end
    endtask

    task automatic drive(input stim_t s);
        reset = s.reset;
        bus0.in_valid = s.in_valid;       bus1.in_valid = s.in_valid;
        bus0.dest = s.dest[2:0];          bus1.dest = s.dest;
        bus0.sr1 = s.sr1[2:0];            bus1.sr1 = s.sr1;
        bus0.sr2 = s.sr2[2:0];            bus1.sr2 = s.sr2;
        bus0.uses_sr1 = s.uses_sr1;       bus1.uses_sr1 = s.uses_sr1;
        bus0.uses_sr2 = s.uses_sr2;       bus1.uses_sr2 = s.uses_sr2;
        bus0.writes_dest = s.writes_dest; bus1.writes_dest = s.writes_dest;
        bus0.is_load = s.is_load;         bus1.is_load = s.is_load;
        bus0.store_sel = s.store_sel;     bus1.store_sel = s.store_sel;
        bus0.jsr_sel = s.jsr_sel;         bus1.jsr_sel = s.jsr_sel;
        bus0.wb_load = s.wb_load;         bus1.wb_load = s.wb_load;
        bus0.wb_dest = s.wb_dest[2:0];    bus1.wb_dest = s.wb_dest;
        bus0.wb_data = s.wb_data[15:0];   bus1.wb_data = s.wb_data;
        bus0.flush = s.flush;             bus1.flush = s.flush;
        bus0.ex_stall = s.ex_stall;       bus1.ex_stall = s.ex_stall;
    endtask

    task automatic check_outputs(input int k);
        logic        ov, wd, il;
        logic [31:0] od, a, b, cnt;
        if (k == 0) begin
            ov = bus0.out_valid; wd = bus0.out_writes_dest; il = bus0.out_is_load;
            od = 32'(bus0.out_dest); a = 32'(bus0.out_srca_data);
            b = 32'(bus0.out_sr2_data); cnt = 32'(bus0.bubble_cnt);
        end else begin
            ov = bus1.out_valid; wd = bus1.out_writes_dest; il = bus1.out_is_load;
            od = 32'(bus1.out_dest); a = bus1.out_srca_data;
            b = bus1.out_sr2_data; cnt = 32'(bus1.bubble_cnt);
        end
        chk($sformatf("c%0d_out_valid%0d", cyc, k), 32'(ov), 32'(m_ov[k]));
        chk($sformatf("c%0d_bubble_cnt%0d", cyc, k), cnt, m_cnt[k]);
        if (m_fk[k]) begin
            chk($sformatf("c%0d_writes_dest%0d", cyc, k), 32'(wd), 32'(m_wd[k]));
            chk($sformatf("c%0d_is_load%0d", cyc, k), 32'(il), 32'(m_il[k]));
        end
        if (m_dk[k]) begin
            chk($sformatf("c%0d_out_dest%0d", cyc, k), od, 32'(m_od[k]));
            chk($sformatf("c%0d_srca%0d", cyc, k), a, m_a[k]);
            chk($sformatf("c%0d_sr2%0d", cyc, k), b, m_b[k]);
        end
    endtask

    // Drive at the falling edge, check in_ready mid-cycle, check registers
    // at the next falling edge.
    task automatic step(input stim_t s);
        logic r0, r1;
        drive(s);
        #1;
        model_step(0, s, r0);
        model_step(1, s, r1);
        chk($sformatf("c%0d_in_ready0", cyc), 32'(bus0.in_ready), 32'(r0));
        chk($sformatf("c%0d_in_ready1", cyc), 32'(bus1.in_ready), 32'(r1));
        @(negedge clk);
        check_outputs(0);
        check_outputs(1);
        cyc++;
    endtask

    function automatic logic [3:0] raddr();
        if ($urandom_range(0, 9) < 7) return 4'($urandom_range(0, 3));
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s = '0;
        s.reset       = ($urandom_range(0, 99) < 2);
        s.in_valid    = ($urandom_range(0, 9) < 8);
        s.dest        = raddr();
        s.sr1         = raddr();
        s.sr2         = raddr();
        s.uses_sr1    = ($urandom_range(0, 9) < 7);
        s.uses_sr2    = ($urandom_range(0, 9) < 5);
        s.writes_dest = ($urandom_range(0, 9) < 8);
        s.is_load     = ($urandom_range(0, 9) < 4);
        s.store_sel   = ($urandom_range(0, 9) < 2);
        s.jsr_sel     = ($urandom_range(0, 9) < 1);
        s.wb_load     = ($urandom_range(0, 9) < 5);
        s.wb_dest     = raddr();
        s.wb_data     = $urandom;
        s.flush       = ($urandom_range(0, 99) < 8);
        s.ex_stall    = ($urandom_range(0, 99) < 20);
        return s;
    endfunction

    initial begin
        stim_t s;
        drive(nop());
        @(negedge clk);

        // Reset state.
        s = nop(); s.reset = 1; step(s);
        chk("rst_valid0", 32'(bus0.out_valid), 32'd0);
        chk("rst_cnt1", 32'(bus1.bubble_cnt), 32'd0);

        // WB write then read of R3.
        s = nop(); s.wb_load = 1; s.wb_dest = 3; s.wb_data = 32'h1234; step(s);
        s = nop(); s.in_valid = 1; s.sr1 = 3; s.uses_sr1 = 1; s.dest = 1; s.writes_dest = 1; step(s);
        chk("rf_read_srca", 32'(bus0.out_srca_data), 32'h1234);
        chk("rf_read_valid", 32'(bus0.out_valid), 32'd1);

        // Same-cycle write-through bypass.
        s = nop(); s.in_valid = 1; s.sr2 = 5; s.uses_sr2 = 1; s.dest = 1; s.writes_dest = 1;
        s.wb_load = 1; s.wb_dest = 5; s.wb_data = 32'hBEEF; step(s);
        chk("bypass_sr2", 32'(bus0.out_sr2_data), 32'hBEEF);

        // Load-use: one bubble then issue.
        s = nop(); s.in_valid = 1; s.is_load = 1; s.writes_dest = 1; s.dest = 2; step(s);
        s = nop(); s.in_valid = 1; s.sr1 = 2; s.uses_sr1 = 1; s.dest = 1; s.writes_dest = 1; step(s);
        chk("hz_bubble_valid", 32'(bus0.out_valid), 32'd0);
        chk("hz_bubble_cnt", 32'(bus0.bubble_cnt), 32'd1);
        step(s);
        chk("hz_issue_valid", 32'(bus0.out_valid), 32'd1);

        // JSR link destination, with R4 written alongside.
        s = nop(); s.in_valid = 1; s.jsr_sel = 1; s.dest = 2; s.writes_dest = 1;
        s.wb_load = 1; s.wb_dest = 4; s.wb_data = 32'h4444; step(s);
        chk("jsr_dest0", 32'(bus0.out_dest), 32'd7);
        chk("jsr_dest1", 32'(bus1.out_dest), 32'd15);

        // Store reads its dest field as source A.
        s = nop(); s.in_valid = 1; s.store_sel = 1; s.dest = 4; s.sr1 = 0; s.uses_sr1 = 1; step(s);
        chk("store_srca", 32'(bus0.out_srca_data), 32'h4444);

        // Stall for three cycles with a load in ID/EX, then flush under stall.
        s = nop(); s.in_valid = 1; s.is_load = 1; s.writes_dest = 1; s.dest = 2; step(s);
        s = nop(); s.in_valid = 1; s.sr1 = 2; s.uses_sr1 = 1; s.dest = 1; s.writes_dest = 1;
        s.ex_stall = 1;
        for (int i = 0; i < 3; i++) begin
            step(s);
            chk("stall_hold_load", 32'(bus0.out_is_load), 32'd1);
            chk("stall_cnt", 32'(bus0.bubble_cnt), 32'd1);
        end
        s.flush = 1; step(s);
        chk("flush_stall_valid", 32'(bus0.out_valid), 32'd0);

        // Hard-wired R0 on the second configuration.
        s = nop(); s.wb_load = 1; s.wb_dest = 0; s.wb_data = 32'hFFFF_FFFF; step(s);
        s = nop(); s.in_valid = 1; s.sr1 = 0; s.uses_sr1 = 1; s.dest = 1; s.writes_dest = 1; step(s);
        chk("r0_read", bus1.out_srca_data, 32'd0);
        s = nop(); s.in_valid = 1; s.is_load = 1; s.writes_dest = 1; s.dest = 0; step(s);
        s = nop(); s.in_valid = 1; s.sr1 = 0; s.uses_sr1 = 1; s.dest = 1; s.writes_dest = 1; step(s);
        chk("r0_no_bubble1", 32'(bus1.out_valid), 32'd1);
        chk("r0_bubble0", 32'(bus0.out_valid), 32'd0);

        // Five hazards: 2-bit counter saturates at 3.
        s = nop(); s.reset = 1; step(s);
        for (int i = 0; i < 5; i++) begin
            s = nop(); s.in_valid = 1; s.is_load = 1; s.writes_dest = 1; s.dest = 1; step(s);
            s = nop(); s.in_valid = 1; s.sr2 = 1; s.uses_sr2 = 1; s.dest = 3; s.writes_dest = 1;
            step(s);
            step(s);
        end
        chk("sat_cnt1", 32'(bus1.bubble_cnt), 32'd3);
        chk("sat_cnt0", 32'(bus0.bubble_cnt), 32'd5);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) step(rnd());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode stage for the LC-3b pipeline. It holds the architectural register file with write-through bypass from writeback and selects the destination and source registers (link register for JSR/TRAP, dest-as-source for stores). It detects load-use hazards against the instruction in its own output register, inserts bubbles, and owns the ID/EX pipeline register with stall, flush and a saturating bubble counter.

## Interface
- WIDTH, 16, data word width
- NREGS, 8, number of architectural registers (power of two, ≥2)
- AW, $clog2(NREGS), register address width
- LINK_REG, NREGS-1, register forced as destination when `jsr_sel`
- R0_ZERO, 0, when 1 register 0 reads as zero, ignores writes and never causes a hazard
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  ID consumes the instruction this cycle
- dest, sr1, sr2  in  AW each  decoded register fields
- uses_sr1, uses_sr2  in  1 each  instruction reads source A / sr2
- writes_dest  in  1  instruction writes a register
- is_load  in  1  instruction is LDR/LDB/LDI
- store_sel  in  1  source A address = `dest` instead of `sr1`
- jsr_sel  in  1  effective destination = LINK_REG
- wb_load  in  1  writeback enable
- wb_dest  in  AW  writeback register
- wb_data  in  WIDTH  writeback data
- flush  in  1  squash ID input and ID/EX contents
- ex_stall  in  1  downstream cannot accept; hold ID/EX
- out_valid  out  1  ID/EX holds a real instruction
- out_dest  out  AW  effective destination
- out_srca_data, out_sr2_data  out  WIDTH each  operand values
- out_writes_dest, out_is_load  out  1 each  registered flags
- bubble_cnt  out  CNT_W  count of hazard bubbles inserted

## Operation
- srcA = store_sel ? dest : sr1; dest_eff = jsr_sel ? LINK_REG : dest.
- Register file: NREGS×WIDTH, all entries cleared on reset, written at the clock edge when wb_load (except R0 when R0_ZERO).
- Read: combinational. If wb_load and wb_dest == address, return wb_data (write-through bypass). With R0_ZERO, address 0 always returns 0, taking priority over the bypass.
- Hazard: hz = in_valid & out_valid & out_is_load & out_writes_dest & ((uses_sr1 & srcA == out_dest) | (uses_sr2 & sr2 == out_dest)). If R0_ZERO and out_dest == 0, hz = 0. `uses_sr1` governs source A even when store_sel is set.
- in_ready = !reset & (flush | (!ex_stall & !hz)).
- ID/EX update priority, highest first:
  1. reset: all outputs are 0.
  2. flush: out_valid and both flags are 0; the input is consumed and discarded.
  3. ex_stall: hold all contents.
  4. hz: insert a bubble. out_valid and both flags are 0; bubble_cnt increments; the input is not consumed.
  5. in_valid: load dest_eff, operands and flags; out_valid is 1.
  6. Otherwise: out_valid is 0.
- Operand values come from the read path in the cycle of capture, including the bypass.
- bubble_cnt saturates at all-ones. It does not increment on flush or during ex_stall.
- EX/MEM/WB forwarding is out of scope; it is handled downstream.

## Timing
- Latency: one cycle from the input being consumed to out_valid.
- Load-use costs exactly one bubble. The next cycle out_valid = 0, so hz = 0 and the instruction issues.
- A waiting instruction re-reads the register file every cycle, so writes arriving during a stall are observed.
- Reset mid-stall or mid-hazard: the next cycle all outputs are 0, the register file is 0, and bubble_cnt is 0.
- flush together with ex_stall: flush wins and out_valid goes to 0.
- flush together with hz: flush wins and no bubble is counted.
- wb_load to the same register as a capturing read: the bypassed value is captured.

## Test plan
- Reset, then write R3 = 0x1234 via WB. ADD reading sr1 = 3 in the next cycle → out_srca_data = 0x1234 one cycle later, out_valid = 1.
- Same-cycle bypass: wb_load R5 = 0xBEEF while the ID input reads sr2 = 5 → captured out_sr2_data = 0xBEEF.
- LDR R2, then ADD using R2 → cycle after LDR: in_ready = 0, next out_valid = 0, bubble_cnt = 1. The ADD issues one cycle later.
- jsr_sel = 1 → out_dest = 7 (NREGS = 8). STR with store_sel = 1, dest = 4 → out_srca_data = R4.
- ex_stall held 3 cycles with the load in ID/EX → outputs frozen, in_ready = 0, bubble_cnt unchanged. flush asserted during the stall → out_valid = 0 the next cycle.
- NREGS = 16, WIDTH = 32, R0_ZERO = 1: write R0 = 0xFFFFFFFF then read → 0. LDR R0 followed by ADD using R0 → no bubble. CNT_W = 2 with 5 hazards → bubble_cnt = 3.
